// File: rtl/i2c_target_regs_if.sv
// Shared SCL/SDA pads plus the register-write side port of the I2C target.
// The slave modport is the target's view; the master modport is the bus driver's view.
interface i2c_target_regs_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_out, wr_valid, wr_addr, wr_data, busy
    );
    modport master (
        output scl_in, sda_in,
        input  sda_out, wr_valid, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with an internal 8-bit register file and a committed-write side port.
// Open-drain SDA only; SCL is never driven, so there is no clock stretching.
module i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR   = 7'h21,
    parameter int unsigned NUM_REGS   = 256,
    parameter int unsigned FILTER_LEN = 3
) (
    input logic              clk,
    input logic              reset,
    i2c_target_regs_if.slave bus
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StDevAddr = 4'd1;
    localparam logic [3:0] StAddrAck = 4'd2;
    localparam logic [3:0] StRegAddr = 4'd3;
    localparam logic [3:0] StRegAck  = 4'd4;
    localparam logic [3:0] StWrData  = 4'd5;
    localparam logic [3:0] StWrAck   = 4'd6;
    localparam logic [3:0] StRdData  = 4'd7;
    localparam logic [3:0] StRdAck   = 4'd8;
    localparam logic [3:0] StIgnore  = 4'd9;

    // Index 1 carries SCL, index 0 carries SDA through sync, filter and edge history.
    logic [1:0]    s1_q, s2_q, filt_q, prev_q;
    logic [CW-1:0] cnt_q [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            filt_q <= 2'b11;
            prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= {bus.scl_in, bus.sda_in};
            s2_q   <= s1_q;
            prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= s2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = filt_q[1] & ~prev_q[1];
    assign scl_fall = ~filt_q[1] & prev_q[1];
    assign start_ev = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
    assign stop_ev  = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];

    logic [3:0] state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, ptr_q, wr_addr_q, wr_data_q;
    logic       rw_q, sda_out_q, wr_valid_q, busy_q;
    logic [7:0] regs_q [2**AW];

    logic [7:0] byte_in, ptr_inc, rd_cur, rd_next;

    function automatic logic [7:0] reg_read(input logic [7:0] p);
        if (32'(p) < NUM_REGS) return regs_q[p[AW-1:0]];
        return 8'hFF;
    endfunction

    assign byte_in = {shift_q[6:0], filt_q[0]};
    assign ptr_inc = ptr_q + 8'd1;
    assign rd_cur  = reg_read(ptr_q);
    assign rd_next = reg_read(ptr_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_out_q  <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 2**AW; i++) regs_q[i] <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_ev) begin
                state_q   <= StDevAddr;
                bit_cnt_q <= '0;
                sda_out_q <= 1'b1;
            end else if (stop_ev) begin
                state_q   <= StIdle;
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                // SDA only moves on SCL fall so it is stable for the whole high phase.
                if (scl_fall) begin
                    case (state_q)
                        StAddrAck, StRegAck, StWrAck: sda_out_q <= 1'b0;
                        StRdData: begin
                            sda_out_q <= shift_q[7];
                            shift_q   <= {shift_q[6:0], 1'b1};
                        end
                        default: sda_out_q <= 1'b1;
                    endcase
                end
                if (scl_rise) begin
                    case (state_q)
                        StDevAddr, StRegAddr, StWrData: begin
                            shift_q   <= byte_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == StDevAddr) begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_q <= StAddrAck;
                                        busy_q  <= 1'b1;
                                        rw_q    <= byte_in[0];
                                    end else begin
                                        state_q <= StIgnore;
                                    end
                                end else if (state_q == StRegAddr) begin
                                    ptr_q   <= byte_in;
                                    state_q <= StRegAck;
                                end else begin
                                    if (32'(ptr_q) < NUM_REGS) regs_q[ptr_q[AW-1:0]] <= byte_in;
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= ptr_q;
                                    wr_data_q  <= byte_in;
                                    ptr_q      <= ptr_inc;
                                    state_q    <= StWrAck;
                                end
                            end
                        end
                        StAddrAck: begin
                            if (rw_q) begin
                                state_q <= StRdData;
                                shift_q <= rd_cur;
                            end else begin
                                state_q <= StRegAddr;
                            end
                        end
                        StRegAck, StWrAck: state_q <= StWrData;
                        StRdData: begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= StRdAck;
                        end
                        StRdAck: begin
                            if (!filt_q[0]) begin
                                ptr_q   <= ptr_inc;
                                shift_q <= rd_next;
                                state_q <= StRdData;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.sda_out  = sda_out_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level bus master, array/pointer reference model,
// directed scenarios followed by randomized read/write transactions.
module tb_i2c_target_regs;
    localparam int unsigned NREGS = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    i2c_target_regs_if bus ();
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & bus.sda_out;  // wired-AND open-drain bus

    i2c_target_regs #(
        .DEV_ADDR  (7'h21),
        .NUM_REGS  (NREGS),
        .FILTER_LEN(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  mreg [256];
    logic [7:0]  mptr;
    logic [15:0] wr_seen[$];
    logic [15:0] wr_exp[$];
    logic        wr_prev = 1'b0;
    int          wr_long = 0;
    logic        watch = 1'b0;
    logic        glitch_en = 1'b0;
    int          drive_viol = 0;
    int          busy_viol = 0;

    always @(negedge clk) begin
        if (bus.wr_valid) wr_seen.push_back({bus.wr_addr, bus.wr_data});
        if (bus.wr_valid && wr_prev) wr_long <= wr_long + 1;
        wr_prev <= bus.wr_valid;
        if (watch && !bus.sda_out) drive_viol <= drive_viol + 1;
        if (watch && bus.busy) busy_viol <= busy_viol + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
        mptr = 8'h00;
    endtask

    // One SCL period starting and ending 8 clk after an SCL fall.
    task automatic bit_xfer(input logic v, output logic r);
        m_sda = v;
        tick(HALF);
        m_scl = 1'b1;
        if (glitch_en) begin
            tick(4);
            m_sda = ~v;
            tick(2);
            m_sda = v;
            tick(HALF - 6);
        end else begin
            tick(HALF);
        end
        r = bus.sda_in;
        tick(HALF);
        m_scl = 1'b0;
        tick(HALF);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(HALF);
        m_scl = 1'b1;
        tick(2 * HALF);
        m_sda = 1'b0;
        tick(2 * HALF);
        m_scl = 1'b0;
        tick(HALF);
    endtask

    task automatic i2c_stop(input logic chk_busy);
        int lat;
        m_sda = 1'b0;
        tick(HALF);
        m_scl = 1'b1;
        tick(2 * HALF);
        if (chk_busy) check("busy_before_stop", bus.busy, 1);
        m_sda = 1'b1;
        lat = 0;
        while (bus.busy && lat < 20) begin
            tick(1);
            lat++;
        end
        // 2 sync + 3 filter cycles to the STOP strobe, busy clears one cycle later.
        if (chk_busy) check("busy_drop_latency", lat, 6);
        tick(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            b = {b[6:0], r};
        end
        bit_xfer(mack, r);
    endtask

    task automatic check_wr();
        check("wr_count", wr_seen.size(), wr_exp.size());
        while (wr_seen.size() > 0 && wr_exp.size() > 0)
            check("wr_event", wr_seen.pop_front(), wr_exp.pop_front());
        wr_seen.delete();
        wr_exp.delete();
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] d[$]);
        logic a;
        i2c_start();
        send_byte(8'h42, a);
        check("wr_dev_ack", a, 0);
        send_byte(p, a);
        check("wr_ptr_ack", a, 0);
        mptr = p;
        foreach (d[i]) begin
            send_byte(d[i], a);
            check("wr_data_ack", a, 0);
            wr_exp.push_back({mptr, d[i]});
            if (32'(mptr) < NREGS) mreg[mptr] = d[i];
            mptr = mptr + 8'd1;
        end
        i2c_stop(1'b1);
        check_wr();
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       a;
        logic [7:0] b;
        logic [7:0] exp;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h42, a);
            check("rd_dev_w_ack", a, 0);
            send_byte(p, a);
            check("rd_ptr_ack", a, 0);
            mptr = p;
            i2c_start();
        end
        send_byte(8'h43, a);
        check("rd_dev_r_ack", a, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            exp = (32'(mptr) < NREGS) ? mreg[mptr] : 8'hFF;
            check("rd_data", b, exp);
            if (i < n - 1) mptr = mptr + 8'd1;
        end
        i2c_stop(1'b1);
    endtask

    initial begin
        logic [7:0] dq[$];
        logic       a;
        logic       r;
        model_clear();

        tick(5);
        check("rst_sda_out", bus.sda_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        reset = 1'b0;
        tick(10);

        // Write burst then read back with master ACK then NACK.
        dq = '{8'h55, 8'hAA};
        do_write(8'h10 % 8'(NREGS), dq);
        do_read(1'b1, 8'h10 % 8'(NREGS), 2);

        // Foreign address: never driven, no commits, busy stays low.
        watch = 1'b1;
        i2c_start();
        send_byte(8'h44, a);
        check("mismatch_nack", a, 1);
        send_byte(8'h10, a);
        check("mismatch_ignored", a, 1);
        i2c_stop(1'b0);
        watch = 1'b0;
        tick(1);
        check("mismatch_sda_driven", drive_viol, 0);
        check("mismatch_busy", busy_viol, 0);
        check("mismatch_wr_valid", wr_seen.size(), 0);
        dq = '{8'h5A};
        do_write(8'h07, dq);
        do_read(1'b1, 8'h07, 1);

        // Pointer wrap and out-of-range reads.
        dq = '{8'h01, 8'h02};
        do_write(8'hFF, dq);
        do_read(1'b1, 8'h00, 1);
        do_read(1'b1, 8'h20, 1);

        // Glitches on SDA during every SCL high phase must not break the transfer.
        glitch_en = 1'b1;
        dq = '{8'hA5, 8'h3C};
        do_write(8'h03, dq);
        glitch_en = 1'b0;
        do_read(1'b1, 8'h03, 2);

        // Reset while the target drives a 0 data bit.
        dq = '{8'h3C};
        do_write(8'h0A, dq);
        i2c_start();
        send_byte(8'h42, a);
        send_byte(8'h0A, a);
        i2c_start();
        send_byte(8'h43, a);
        check("rst_mid_dev_ack", a, 0);
        m_sda = 1'b1;
        tick(HALF);
        m_scl = 1'b1;
        tick(4);
        check("rst_mid_bit_driven", bus.sda_out, 0);
        reset = 1'b1;
        tick(1);
        check("rst_mid_release", bus.sda_out, 1);
        check("rst_mid_busy", bus.busy, 0);
        reset = 1'b0;
        model_clear();
        watch = 1'b1;
        tick(4);
        m_scl = 1'b0;
        tick(HALF);
        for (int i = 0; i < 8; i++) bit_xfer(1'b0, r);
        i2c_stop(1'b0);
        watch = 1'b0;
        tick(1);
        check("rst_mid_sda_driven", drive_viol, 0);
        check("rst_mid_busy_after", busy_viol, 0);
        check("rst_mid_wr_valid", wr_seen.size(), 0);
        do_read(1'b1, 8'h0A, 1);

        // Randomized transactions against the model.
        for (int t = 0; t < 14; t++) begin
            int op;
            int len;
            logic [7:0] p;
            op  = $urandom_range(0, 2);
            len = $urandom_range(1, 3);
            p   = ($urandom_range(0, 5) == 0) ? 8'hFE : 8'($urandom_range(0, 20));
            if (op == 0) begin
                dq.delete();
                for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
                do_write(p, dq);
            end else if (op == 1) begin
                do_read(1'b1, p, len);
            end else begin
                do_read(1'b0, 8'h00, len);
            end
        end

        check("wr_valid_one_cycle", wr_long, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with an internal 8-bit register file; the bus-side counterpart of the camera I2C stream bridge. It serves as a synthesizable SCCB/I2C camera model for loopback benches and as an on-chip configuration target. The block is an open-drain peer on a shared SCL/SDA pair. It decodes START/STOP, matches a 7-bit device address, accepts register-pointer writes and data bursts, returns read bursts, and reports every register write on a side port.

## Interface
- DEV_ADDR, 7'h21: 7-bit target address; 8'h42 is the write byte and 8'h43 the read byte.
- NUM_REGS, 256: number of implemented registers (1..256), at addresses 0..NUM_REGS-1.
- FILTER_LEN, 3: glitch-filter depth in clk cycles for synchronized SCL/SDA.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  bus SCL level (asynchronous).
- sda_in  input  1  bus SDA level (asynchronous).
- sda_out  output  1  0 pulls SDA low; 1 releases it (external tristate).
- wr_valid  output  1  one-cycle pulse per committed data byte.
- wr_addr  output  8  register pointer of the committed byte.
- wr_data  output  8  committed byte.
- busy  output  1  high from an address match until STOP.

## Operation
- Input conditioning: 2-flop synchronizer, then a filter; the filtered level changes only after FILTER_LEN identical consecutive samples.
- Event decode on filtered signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise and SCL fall are single-cycle strobes.
- START or STOP overrides every state. START (including repeated start) goes to DEVADDR. STOP goes to IDLE. Both release sda_out and clear busy on STOP.
- States: IDLE, DEVADDR, ADDR_ACK, REGADDR, REG_ACK, WRDATA, WR_ACK, RDDATA, RD_ACK, IGNORE.
- DEVADDR: shift 8 bits MSB first on SCL rise.
  - Address match: go to ADDR_ACK, set busy.
  - Mismatch: go to IGNORE, SDA stays released (NACK). IGNORE waits for START/STOP.
- ADDR_ACK:
  - R/W=0: next state REGADDR.
  - R/W=1: next state RDDATA; load shift register with reg[ptr].
- REGADDR: 8 bits become ptr. Then REG_ACK, then WRDATA.
- WRDATA: 8 bits, then WR_ACK. Then:
  - If ptr < NUM_REGS, reg[ptr] is written.
  - wr_valid pulses regardless of range.
  - ptr increments. Stay in the WRDATA/WR_ACK loop.
- RDDATA: drive the shift register MSB first, then release SDA for RD_ACK. Master response sampled on SCL rise:
  - ACK (0): ptr increments, reload from the new ptr, back to RDDATA.
  - NACK (1): go to IGNORE.
- Out-of-range read (ptr >= NUM_REGS) returns 8'hFF.
- ptr is 8 bits and wraps 8'hFF -> 8'h00. ptr persists across transactions; reset clears it.
- No clock stretching: SCL is never driven.
- Reset:
  - sda_out=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - ptr=0, all registers 8'h00, state IDLE.
  - Reset mid-transaction releases SDA on the next clk. Bus traffic is ignored until a fresh START.

## Timing
- Input latency: 2 sync + FILTER_LEN cycles from pad to filtered level.
- Bus requirement: SCL high and low phases each at least FILTER_LEN+4 clk cycles. SDA setup/hold around SCL edges at least FILTER_LEN+2 cycles. 400 kHz at 200 MHz clk is far inside this.
- Data bits are sampled on the SCL-rise strobe. sda_out changes only on the SCL-fall strobe, 1 clk after the strobe. It therefore never changes while SCL is high, so no false START/STOP is generated.
- ACK drive: sda_out=0 from the fall after bit 8 to the following fall, then released (or next read bit driven).
- Commit timing: wr_valid, wr_addr and wr_data are updated in the cycle after the bit-8 SCL-rise strobe. wr_valid is high for exactly 1 cycle. The register-file write is in the same cycle.
- Read-data load: on the SCL-rise strobe of the ACK bit; first bit driven on the following SCL fall.
- busy rises in the cycle after the bit-8 rise of a matching address. It falls 1 cycle after the STOP strobe.

## Test plan
- Write burst:
  - Stimulus: S 42 A 10 A 55 A AA A P.
  - Required response: target ACKs all four bytes. wr_valid pulses twice: (10,55), then (11,AA). ptr=12 after.
- Read back:
  - Stimulus: S 42 10 Sr 43, master ACK then NACK.
  - Required response: returns 55, AA. ACK after 43. busy drops 1 cycle after P.
- Address mismatch:
  - Stimulus: S 44 ...
  - Required response: SDA never driven, no wr_valid, busy stays 0. A following S 42 transaction succeeds.
- Wrap and range with NUM_REGS=16:
  - Write ptr=FF with data 01, 02: wr_addr FF then 00, reg[0]=02.
  - Read ptr=20: returns FF.
- Reset mid-read:
  - Stimulus: assert reset while the target drives a 0 data bit.
  - Required response: sda_out=1 next cycle. Remaining SCL clocks are ignored until a new S. reg[10] reads 00.
- Glitch:
  - Stimulus: 2-cycle SDA pulse while SCL is high.
  - Required response: with FILTER_LEN=3, no START/STOP is detected and the transfer completes intact.
